// File: rtl/mfp_seven_segment_pkg.sv
// Shared constants for the 7-segment scanner: active-high font table,
// inactive-level constants for the active-low pins, and the default slot length.
package mfp_seven_segment_pkg;

  localparam int DIGIT_PERIOD_DEF = 1024;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic       ANODE_OFF = 1'b1;

  // Index n holds the gfedcba pattern for hex digit n (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/mfp_hex_to_seven_segment.sv
// Combinational nibble to active-high gfedcba segment pattern.
module mfp_hex_to_seven_segment
  import mfp_seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/mfp_seven_segment_scanner.sv
// Time-multiplexed driver for an N-digit common-anode display. Inputs are
// snapshotted once per frame so a frame never mixes two hex words.
module mfp_seven_segment_scanner
  import mfp_seven_segment_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int DIGIT_PERIOD = DIGIT_PERIOD_DEF,
  parameter int CNT_WIDTH    = $clog2(DIGIT_PERIOD)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [N_DIGITS*4-1:0] hex_word,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  blank_lz,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_WIDTH-1:0]        cnt;
  logic [IDX_W-1:0]            idx;
  logic [N_DIGITS-1:0][3:0]    sh_hex;
  logic [N_DIGITS-1:0]         sh_dp;
  logic                        sh_blz;
  logic                        load_pending;

  logic                        tick;
  logic                        last_digit;
  logic                        load;
  logic [N_DIGITS-1:0]         zero_above;
  logic                        blanked;
  logic [6:0]                  seg_raw;

  assign tick       = (cnt == CNT_WIDTH'(DIGIT_PERIOD - 1));
  assign last_digit = (idx == IDX_W'(N_DIGITS - 1));
  assign load       = load_pending | (tick & last_digit);

  // zero_above[i]: nibbles i..N_DIGITS-1 are all zero.
  always_comb begin
    zero_above = '0;
    zero_above[N_DIGITS-1] = (sh_hex[N_DIGITS-1] == 4'h0);
    for (int i = N_DIGITS - 2; i >= 0; i--)
      zero_above[i] = zero_above[i+1] & (sh_hex[i] == 4'h0);
  end

  assign blanked = sh_blz & (idx != '0) & zero_above[idx];

  mfp_hex_to_seven_segment u_dec (
    .nibble (sh_hex[idx]),
    .seg    (seg_raw)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt          <= '0;
      idx          <= '0;
      sh_hex       <= '0;
      sh_dp        <= '0;
      sh_blz       <= 1'b0;
      load_pending <= 1'b1;
      anodes       <= {N_DIGITS{ANODE_OFF}};
      segments     <= SEG_OFF;
      dp           <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= last_digit ? '0 : idx + 1'b1;
      if (load) begin
        sh_hex <= hex_word;
        sh_dp  <= dp_mask;
        sh_blz <= blank_lz;
      end
      load_pending <= 1'b0;
      frame_start  <= load;
      // First cycle of every slot keeps all anodes off to hide ghosting.
      anodes   <= ((cnt == '0) || blanked) ? {N_DIGITS{ANODE_OFF}}
                                           : ~(N_DIGITS'(1) << idx);
      segments <= ~seg_raw;
      dp       <= ~sh_dp[idx];
    end
  end

endmodule

// File: tb/tb_mfp_seven_segment_scanner.sv
// Scanner bench: directed scenarios plus random inputs, all checked every
// cycle against a time-based model of what the display should show.
module tb_mfp_seven_segment_scanner;

  localparam int N     = 8;
  localparam int P     = 4;
  localparam int FRAME = N * P;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b0;
  logic [N*4-1:0] hex_word = '0;
  logic [N-1:0]   dp_mask = '0;
  logic           blank_lz = 1'b0;
  logic [N-1:0]   anodes;
  logic [6:0]     segments;
  logic           dp;
  logic           frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: c = clock edges since reset released; frame content latched at
  // c==0 and at the last cycle of every frame.
  int             c = 0;
  logic [N*4-1:0] m_hex = '0;
  logic [N-1:0]   m_dp = '0;
  logic           m_blz = 1'b0;
  logic [N-1:0]   e_an;
  logic [6:0]     e_seg;
  logic           e_dp, e_fs;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  mfp_seven_segment_scanner #(.N_DIGITS(N), .DIGIT_PERIOD(P)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .hex_word    (hex_word),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .anodes      (anodes),
    .segments    (segments),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    int slot, d;
    logic blank, load;
    if (!HRESETn) begin
      c = 0; m_hex = '0; m_dp = '0; m_blz = 1'b0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      slot  = c % P;
      d     = (c / P) % N;
      blank = (d > 0) && m_blz && ((m_hex >> (4 * d)) == '0);
      e_an  = (slot == 0 || blank) ? '1 : ~(N'(1) << d);
      e_seg = ~font[m_hex[4*d +: 4]];
      e_dp  = ~m_dp[d];
      load  = (c == 0) || (c % FRAME == FRAME - 1);
      e_fs  = load;
      if (load) begin
        m_hex = hex_word; m_dp = dp_mask; m_blz = blank_lz;
      end
      c++;
    end
  endtask

  task automatic cycle();
    @(posedge HCLK);
    model_edge();
    @(negedge HCLK);
    cyc++;
    chk("anodes", anodes, e_an);
    chk("segments", segments, e_seg);
    chk("dp", dp, e_dp);
    chk("frame_start", frame_start, e_fs);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model sits at frame offset 'pos' (bounded by one frame).
  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (c % FRAME) != pos; i++) cycle();
  endtask

  initial begin
    hex_word = 32'h0123_4567;
    HRESETn  = 1'b0;
    run(3);
    chk("rst_anodes", anodes, 8'hFF);
    chk("rst_segments", segments, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_frame_start", frame_start, 1'b0);
    HRESETn = 1'b1;
    cycle();
    chk("post_rst_fs_pulse", frame_start, 1'b1);
    cycle();
    chk("post_rst_fs_single", frame_start, 1'b0);
    // Digit 0 slot: cycle c=2 shows '7' on digit 0.
    chk("digit0_anodes", anodes, 8'hFE);
    chk("digit0_seg7", segments, 7'h78);
    run(2 * FRAME);

    // Tear-free: swap the word while digit 3 is active.
    hex_word = 32'h1111_1111;
    run_to(0);
    run(FRAME);
    run_to(3 * P + 2);
    hex_word = 32'h2222_2222;
    run(2 * FRAME);

    // Leading-zero blanking.
    blank_lz = 1'b1; hex_word = 32'h0000_00A0;
    run(3 * FRAME);
    blank_lz = 1'b1; hex_word = '0; dp_mask = 8'h04;
    run(2 * FRAME);
    blank_lz = 1'b0;
    run(2 * FRAME);

    // Reset during digit 5.
    hex_word = 32'h89AB_CDEF; dp_mask = 8'hA5;
    run_to(5 * P + 2);
    HRESETn = 1'b0;
    cycle();
    chk("midrst_anodes", anodes, 8'hFF);
    chk("midrst_segments", segments, 7'h7F);
    HRESETn = 1'b1;
    run(2 * FRAME);

    // Random inputs, with random leading-zero counts and rare resets.
    for (int i = 0; i < 40 * FRAME; i++) begin
      if ($urandom_range(7) == 0) begin
        hex_word = $urandom & (32'hFFFF_FFFF >> (4 * $urandom_range(8)));
        dp_mask  = N'($urandom);
        blank_lz = 1'($urandom);
      end
      HRESETn = ($urandom_range(299) != 0);
      cycle();
    end
    HRESETn = 1'b1;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfp_seven_segment_scanner.md
Name: mfp_seven_segment_scanner

Overview:
Time-multiplexed driver for the board's 8-digit common-anode 7-segment display. It consumes the packed hex word produced by the GPIO slave's 7-segment register (one nibble per digit) and scans one digit at a time, with anode and segment outputs active-low. It sits between the GPIO slave's IO_7_SegmentHEX output and the board pins. Each frame is snapshotted atomically to avoid tearing, with optional leading-zero blanking and an anti-ghost blank slot.

Parameters:
N_DIGITS, 8, number of digits; hex_word is N_DIGITS*4 bits wide.
DIGIT_PERIOD, 1024, clock cycles each digit is selected; must be >= 2.
CNT_WIDTH, $clog2(DIGIT_PERIOD), width of the slot counter (derived; do not override).

Ports:
HCLK  input  1  system clock
HRESETn  input  1  reset, synchronous, active-low
hex_word  input  N_DIGITS*4  nibble i drives digit i (digit 0 = rightmost, bits [3:0])
dp_mask  input  N_DIGITS  bit i = 1 lights decimal point of digit i
blank_lz  input  1  1 = blank leading zero digits
anodes  output  N_DIGITS  digit select, active-low, registered
segments  output  7  segments a..g in bits [0]..[6], active-low, registered
dp  output  1  decimal point, active-low, registered
frame_start  output  1  one-cycle pulse, registered

Behaviour:
- Clock/reset: one clock HCLK; reset HRESETn is synchronous, active-low. All state is sampled on the HCLK rising edge.
- Reset values: slot counter 0, digit index 0, shadow registers 0, anodes all 1, segments 7'h7F, dp 1, frame_start 0, load_pending 1.
- Slot counter:
  - Counts 0..DIGIT_PERIOD-1, then wraps to 0.
  - The wrap cycle is the tick; on a tick the digit index increments and wraps from N_DIGITS-1 to 0.
- Snapshot:
  - hex_word, dp_mask and blank_lz are copied into shadow registers on a tick that wraps the index to 0.
  - They are also copied on the first cycle after reset (load_pending=1), which then clears load_pending.
  - Between snapshots, input changes have no visible effect.
- frame_start: 1 for exactly one cycle, in the cycle after each snapshot load, including the post-reset load.
- Outputs are registered from (counter, index, shadow), so they lag the internal index by 1 cycle.
- Anti-ghost: while counter==0 (first cycle of each slot), anodes are all 1. Segments and dp already carry the new digit's value.
- Digit active (counter!=0): anodes has only bit index = 0. segments = ~decode(shadow nibble[index]); dp = ~shadow_dp[index].
- Leading-zero blanking: digit i (i>=1) is blanked when shadow blank_lz=1 and nibbles i..N_DIGITS-1 are all zero.
  - A blanked digit keeps anodes all 1 for its whole slot.
  - Digit 0 is never blanked.
- Decode, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - The output is the bitwise inverse of this value.
- Reset mid-frame: state and outputs take their reset values on the next edge. The scan restarts at digit 0 with a fresh snapshot.
- Full frame length: N_DIGITS*DIGIT_PERIOD cycles; the scan is free-running with no stall condition.

Decomposition:
- Shared package/header mfp_seven_segment_pkg holds:
  - the 16-entry decode table (active-high);
  - ANODE_OFF/SEG_OFF constants;
  - the default DIGIT_PERIOD.
- One natural sub-module: mfp_hex_to_seven_segment, a combinational 4-bit nibble to 7-bit active-high decoder, instantiated once on the selected nibble.

Test Plan:
- Reset: hold HRESETn=0 for 3 cycles -> anodes=8'hFF, segments=7'h7F, dp=1, frame_start=0. Release -> frame_start pulses once on the 2nd cycle after release.
- Scan with DIGIT_PERIOD=4, hex_word=32'h0123_4567, dp_mask=0, blank_lz=0:
  - Slot 0: 1 cycle with anodes=8'hFF, then 3 cycles with anodes=8'hFE, segments=7'h78 ('7').
  - Slot 7: anodes=8'h7F, segments=7'h40 ('0').
  - Frame repeats every 32 cycles.
- Tear-free: change hex_word from 32'h1111_1111 to 32'h2222_2222 while digit 3 is active -> digits 4..7 still show 7'h79 ('1') in the current frame. Next frame shows 7'h24 ('2') on all digits, starting after frame_start.
- Blanking: blank_lz=1, hex_word=32'h0000_00A0 -> digits 2..7 keep anodes=8'hFF for their whole slots. Digit 1 shows 7'h08 ('A'); digit 0 shows 7'h40 ('0').
- All zero: blank_lz=1, hex_word=0, dp_mask=8'h04 -> only digit 0 is lit (7'h40); digit 2 is blanked even though its dp bit is set. With blank_lz=0, dp=0 in the digit 2 slot.
- Reset mid-frame: assert HRESETn=0 for 1 cycle during digit 5 -> reset values on the next edge. The scan resumes at digit 0 with a new snapshot and frame_start pulse.
